// File: rtl/sme_pkg.sv
// Shared types and constants for the SME front-end arbiter.
// MAX_STR_ADD normally comes from the SME parameter header; the fallback keeps this slice standalone.
`ifndef MAX_STR_ADD
`define MAX_STR_ADD 8
`endif

package sme_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT,
    ST_RESP
  } sme_state_e;

  localparam int TIMEOUT_DEF = 1024;
  localparam int IDX_W       = `MAX_STR_ADD;

endpackage

// File: rtl/sme_arbiter_if.sv
// Requester/SME bus of the arbiter: per-requester job streams, SME character port and result returns.
interface sme_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = sme_pkg::IDX_W
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   in_valid;
  logic [8*NUM_REQ-1:0] in_char;
  logic [NUM_REQ-1:0]   in_isstring;
  logic [NUM_REQ-1:0]   in_last;
  logic [7:0]           sme_chardata;
  logic                 sme_isstring;
  logic                 sme_ispattern;
  logic                 sme_valid;
  logic                 sme_match;
  logic [IDX_W-1:0]     sme_match_index;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic                 rsp_match;
  logic [IDX_W-1:0]     rsp_index;
  logic                 rsp_timeout;
  logic                 busy;

  modport slave (
    input  req, in_valid, in_char, in_isstring, in_last,
           sme_valid, sme_match, sme_match_index,
    output gnt, sme_chardata, sme_isstring, sme_ispattern,
           rsp_valid, rsp_match, rsp_index, rsp_timeout, busy
  );

  modport master (
    output req, in_valid, in_char, in_isstring, in_last,
           sme_valid, sme_match, sme_match_index,
    input  gnt, sme_chardata, sme_isstring, sme_ispattern,
           rsp_valid, rsp_match, rsp_index, rsp_timeout, busy
  );
endinterface

// File: rtl/sme_rr_arb.sv
// Combinational round-robin picker: the search starts just after the last granted index.
module sme_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((int'(last_i) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sme_arbiter.sv
// Shares one SME between NUM_REQ requesters: grants a job, forwards its characters one cycle
// late, waits for the SME result (or a timeout) and returns it to the job owner.
module sme_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = sme_pkg::TIMEOUT_DEF,
  parameter int IDX_W   = sme_pkg::IDX_W
) (
  input logic          clk,
  input logic          reset,
  sme_arbiter_if.slave bus
);
  import sme_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  sme_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         char_q, char_d;
  logic               isstr_q, isstr_d;
  logic               ispat_q, ispat_d;
  logic               match_q, match_d;
  logic               tout_q, tout_d;
  logic [IDX_W-1:0]   index_q, index_d;

  logic               s_valid, s_isstr, s_last;
  logic [7:0]         s_char;

  sme_rr_arb #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_arb (
    .req_i  (bus.req),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  // Only the current owner's stream is visible to the FSM.
  always_comb begin
    s_valid = 1'b0;
    s_char  = '0;
    s_isstr = 1'b0;
    s_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q[i]) begin
        s_valid = bus.in_valid[i];
        s_char  = bus.in_char[8*i +: 8];
        s_isstr = bus.in_isstring[i];
        s_last  = bus.in_last[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    isstr_d = 1'b0;
    ispat_d = 1'b0;
    match_d = match_q;
    tout_d  = tout_q;
    index_d = index_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          owner_d = pick;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) last_d = PTR_W'(i);
          end
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (s_valid) begin
          char_d  = s_char;
          isstr_d = s_isstr;
          ispat_d = !s_isstr;
          // in_last on a string character is a protocol error and is not acted on.
          if (s_last && !s_isstr) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        if (bus.sme_valid) begin
          match_d = bus.sme_match;
          index_d = bus.sme_match_index;
          tout_d  = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          match_d = 1'b0;
          index_d = '0;
          tout_d  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= PTR_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      char_q  <= '0;
      isstr_q <= 1'b0;
      ispat_q <= 1'b0;
      match_q <= 1'b0;
      tout_q  <= 1'b0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      isstr_q <= isstr_d;
      ispat_q <= ispat_d;
      match_q <= match_d;
      tout_q  <= tout_d;
      index_q <= index_d;
    end
  end

  assign bus.gnt           = (state_q == ST_STREAM) ? owner_q : '0;
  assign bus.rsp_valid     = (state_q == ST_RESP) ? owner_q : '0;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.sme_chardata  = char_q;
  assign bus.sme_isstring  = isstr_q;
  assign bus.sme_ispattern = ispat_q;
  assign bus.rsp_match     = match_q;
  assign bus.rsp_index     = index_q;
  assign bus.rsp_timeout   = tout_q;

endmodule

// File: tb/tb_sme_arbiter.sv
// Scoreboard bench for sme_arbiter: directed jobs push expected SME frames and results,
// a negedge monitor pops and compares them whenever the DUT presents framing or rsp_valid.
module tb_sme_arbiter;

  localparam int TMO = 16;

  typedef struct { logic str; logic [7:0] ch; int cyc; } ch_t;
  typedef struct { logic [1:0] own; logic m; logic [7:0] idx; logic to; int cyc; } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  ch_t  exp_ch[$];
  rsp_t exp_rsp[$];
  ch_t  ce;
  rsp_t re;

  sme_arbiter_if #(.NUM_REQ(2), .IDX_W(8)) bus ();

  sme_arbiter #(.NUM_REQ(2), .TIMEOUT(TMO), .IDX_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every framed character and every result pulse must match the next queued entry.
  always @(negedge clk) begin
    if (bus.sme_isstring || bus.sme_ispattern) begin
      if (exp_ch.size() == 0) chk("frame_unexpected", {bus.sme_isstring, bus.sme_ispattern}, 2'b00);
      else begin
        ce = exp_ch.pop_front();
        chk("frame_isstring", bus.sme_isstring, ce.str);
        chk("frame_ispattern", bus.sme_ispattern, !ce.str);
        chk("frame_char", bus.sme_chardata, ce.ch);
        chk("frame_cycle", cyc, ce.cyc);
      end
    end
    if (bus.rsp_valid != 2'b00) begin
      if (exp_rsp.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 2'b00);
      else begin
        re = exp_rsp.pop_front();
        chk("rsp_owner", bus.rsp_valid, re.own);
        chk("rsp_match", bus.rsp_match, re.m);
        chk("rsp_index", bus.rsp_index, re.idx);
        chk("rsp_timeout", bus.rsp_timeout, re.to);
        chk("rsp_cycle", cyc, re.cyc);
      end
    end
  end

  task automatic clear_inputs();
    bus.in_valid = '0;
    bus.in_char = '0;
    bus.in_isstring = '0;
    bus.in_last = '0;
    bus.sme_valid = 1'b0;
    bus.sme_match = 1'b0;
    bus.sme_match_index = '0;
  endtask

  // Owner stream plus noise on the other requester and a stray sme_valid the DUT must ignore.
  task automatic drive(input int o, input bit v, input logic [7:0] ch, input bit str, input bit last);
    int oth;
    oth = 1 - o;
    bus.in_valid = '0;
    bus.in_isstring = '0;
    bus.in_last = '0;
    bus.in_char = '0;
    bus.in_valid[o] = v;
    bus.in_char[8*o +: 8] = ch;
    bus.in_isstring[o] = str;
    bus.in_last[o] = last;
    bus.in_valid[oth] = 1'b1;
    bus.in_char[8*oth +: 8] = 8'hEE;
    bus.in_last[oth] = 1'b1;
    bus.sme_valid = 1'b1;
    bus.sme_match = 1'b1;
    bus.sme_match_index = 8'hA5;
  endtask

  task automatic reset_checks();
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_isstring", bus.sme_isstring, 1'b0);
    chk("rst_ispattern", bus.sme_ispattern, 1'b0);
    chk("rst_chardata", bus.sme_chardata, 8'h00);
    chk("rst_rsp_match", bus.rsp_match, 1'b0);
    chk("rst_rsp_index", bus.rsp_index, 8'h00);
    chk("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
  endtask

  task automatic run_job(input int o, input string s, input string p, input bit keep,
                         input bit respond, input bit m, input logic [7:0] idx, input int d);
    int n;
    int c;
    logic [1:0] oh;
    oh = 2'b01 << o;
    c = 0;
    n = 0;
    while (bus.gnt == 2'b00 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("grant", bus.gnt, oh);
    if (!keep) bus.req[o] = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      drive(o, 1'b1, s[i], 1'b1, i == s.len() - 1);
      exp_ch.push_back('{1'b1, s[i], cyc + 1});
      @(posedge clk); #1;
    end
    if (s.len() > 0) begin
      drive(o, 1'b0, 8'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("char_hold", bus.sme_chardata, s[s.len()-1]);
      chk("grant_held", bus.gnt, oh);
    end
    for (int i = 0; i < p.len(); i++) begin
      drive(o, 1'b1, p[i], 1'b0, i == p.len() - 1);
      exp_ch.push_back('{1'b0, p[i], cyc + 1});
      c = cyc;
      @(posedge clk); #1;
    end
    if (respond) exp_rsp.push_back('{oh, m, idx, 1'b0, c + 2 + d});
    else exp_rsp.push_back('{oh, 1'b0, 8'h00, 1'b1, c + 1 + TMO});
    clear_inputs();
    chk("grant_clear", bus.gnt, 2'b00);
    chk("busy_wait", bus.busy, 1'b1);
    if (respond) begin
      repeat (d) @(posedge clk);
      #1;
      bus.sme_valid = 1'b1;
      bus.sme_match = m;
      bus.sme_match_index = idx;
      @(posedge clk); #1;
      bus.sme_valid = 1'b0;
    end
    n = 0;
    while (exp_rsp.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_rsp.size() != 0) begin
      chk("rsp_arrived", exp_rsp.size(), 0);
      exp_rsp.delete();
    end
    chk("hold_match", bus.rsp_match, respond ? m : 1'b0);
    chk("hold_index", bus.rsp_index, respond ? idx : 8'h00);
    chk("hold_timeout", bus.rsp_timeout, !respond);
    chk("busy_idle", bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    reset_checks();

    // Contention from reset: grants alternate 0,1,0,1; first job is the abc/b example.
    bus.req = 2'b11;
    run_job(0, "abc", "b", 1'b1, 1'b1, 1'b1, 8'd1, 2);
    run_job(1, "xy", "yx", 1'b1, 1'b1, 1'b0, 8'd0, 0);
    run_job(0, "s", "t", 1'b1, 1'b1, 1'b1, 8'd9, 1);
    run_job(1, "uv", "v", 1'b1, 1'b1, 1'b1, 8'd4, 3);
    bus.req = 2'b00;

    // Pattern-only job reusing the loaded string.
    bus.req = 2'b10;
    run_job(1, "", "zz", 1'b0, 1'b1, 1'b1, 8'd2, 1);

    // SME never answers: timeout result.
    bus.req = 2'b01;
    run_job(0, "ab", "q", 1'b0, 1'b0, 1'b0, 8'd0, 0);

    // sme_valid exactly on the terminal-count cycle wins over the timeout.
    bus.req = 2'b10;
    run_job(1, "c", "d", 1'b0, 1'b1, 1'b1, 8'd3, TMO - 1);

    // Stray sme_valid while idle must not produce a result.
    bus.sme_valid = 1'b1;
    bus.sme_match = 1'b1;
    bus.sme_match_index = 8'h5A;
    @(posedge clk); #1;
    bus.sme_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", bus.busy, 1'b0);

    // Reset in the middle of a job owned by requester 0.
    bus.req = 2'b01;
    run_reset_job();
    reset_checks();

    bus.req = 2'b11;
    run_job(0, "k", "k", 1'b1, 1'b1, 1'b0, 8'd6, 0);
    bus.req = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    chk("frames_pending", exp_ch.size(), 0);
    chk("rsp_pending", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  task automatic run_reset_job();
    int n;
    n = 0;
    while (bus.gnt == 2'b00 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_job_grant", bus.gnt, 2'b01);
    bus.req = 2'b00;
    drive(0, 1'b1, "m", 1'b1, 1'b0);
    exp_ch.push_back('{1'b1, 8'h6d, cyc + 1});
    @(posedge clk); #1;
    drive(0, 1'b1, "n", 1'b1, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_inputs();
  endtask

endmodule
